// File: rtl/hazard_stall_controller.sv
// Hazard and stall sequencing for the 5-stage ARM pipeline (IF, ID, EX, MEM, WB).
// Forwarding selects and pipeline enables are combinational from the current
// state and stage inputs; the state, flush counter, memory-wait timer, sticky
// fault flag and stall counter are registered.
module hazard_stall_controller #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       id_rn,
  input  logic [3:0]       id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic [3:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [3:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [3:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             cu_nop_select,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             ex_mem_hold,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    FAULT    = 2'd3
  } state_t;

  // A branch seen in RUN or FLUSH is itself the first flush cycle, so the
  // counter is loaded with the remaining count. A branch accepted on the
  // memory-ready cycle has not flushed yet, so it loads the full count.
  localparam logic [2:0] FLUSH_FULL   = 3'(FLUSH_CYCLES);
  localparam logic [2:0] FLUSH_REMAIN = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TIMEOUT      = 8'(MEM_TIMEOUT);

  state_t     state;
  logic [2:0] flush_cnt;
  logic [7:0] mem_timer;

  logic       ex_hit_a, ex_hit_b;
  logic       load_use;
  logic [1:0] raw_fwd_a, raw_fwd_b;

  // A stage matches a source operand only when the operand is really read,
  // the stage really writes, the indices agree and the index is not the PC.
  function automatic logic stage_hit(input logic use_r, input logic [3:0] src,
                                     input logic [3:0] rd, input logic rw);
    return use_r && rw && (src == rd) && (src != 4'd15);
  endfunction

  // Youngest producer wins; a load in EX cannot forward yet, so it falls
  // through to the older stages while the bubble logic takes care of it.
  function automatic logic [1:0] pick_fwd(input logic ex_hit, input logic ex_load,
                                          input logic mem_hit, input logic wb_hit);
    if (ex_hit && !ex_load) return 2'b01;
    if (mem_hit)            return 2'b10;
    if (wb_hit)             return 2'b11;
    return 2'b00;
  endfunction

  assign ex_hit_a  = stage_hit(id_use_rn, id_rn, ex_rd, ex_reg_write);
  assign ex_hit_b  = stage_hit(id_use_rm, id_rm, ex_rd, ex_reg_write);
  assign load_use  = ex_mem_read && (ex_hit_a || ex_hit_b);
  assign raw_fwd_a = pick_fwd(ex_hit_a, ex_mem_read,
                              stage_hit(id_use_rn, id_rn, mem_rd, mem_reg_write),
                              stage_hit(id_use_rn, id_rn, wb_rd, wb_reg_write));
  assign raw_fwd_b = pick_fwd(ex_hit_b, ex_mem_read,
                              stage_hit(id_use_rm, id_rm, mem_rd, mem_reg_write),
                              stage_hit(id_use_rm, id_rm, wb_rd, wb_reg_write));

  // Pipeline control: forced safe values in reset, otherwise decided by state
  // with branch > memory wait > load-use priority while running.
  always_comb begin
    fwd_a_sel     = raw_fwd_a;
    fwd_b_sel     = raw_fwd_b;
    cu_nop_select = 1'b0;
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    if_id_flush   = 1'b0;
    ex_mem_hold   = 1'b0;
    if (!reset_n) begin
      fwd_a_sel     = 2'b00;
      fwd_b_sel     = 2'b00;
      cu_nop_select = 1'b1;
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            if_id_flush   = 1'b1;
            cu_nop_select = 1'b1;
          end else if (mem_req && !mem_ready) begin
            cu_nop_select = 1'b0;
          end else if (load_use) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            cu_nop_select = 1'b1;
          end
        end
        MEM_WAIT: begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          ex_mem_hold  = 1'b1;
        end
        FLUSH: begin
          if_id_flush   = 1'b1;
          cu_nop_select = 1'b1;
        end
        default: begin
          pc_enable     = 1'b0;
          if_id_enable  = 1'b0;
          ex_mem_hold   = 1'b1;
          cu_nop_select = 1'b1;
        end
      endcase
    end
  end

  // State sequencing, flush countdown, memory-wait timeout, sticky fault and
  // the saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= RUN;
      flush_cnt   <= 3'd0;
      mem_timer   <= 8'd0;
      mem_fault   <= 1'b0;
      stall_count <= '0;
    end else begin
      if (!pc_enable && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
      case (state)
        RUN: begin
          if (branch_taken) begin
            state     <= (FLUSH_CYCLES == 1) ? RUN : FLUSH;
            flush_cnt <= FLUSH_REMAIN;
          end else if (mem_req && !mem_ready) begin
            state     <= MEM_WAIT;
            mem_timer <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            if (branch_taken) begin
              state     <= FLUSH;
              flush_cnt <= FLUSH_FULL;
            end else begin
              state <= RUN;
            end
          end else if (mem_timer >= TIMEOUT) begin
            state     <= FAULT;
            mem_fault <= 1'b1;
          end else begin
            mem_timer <= mem_timer + 8'd1;
          end
        end
        FLUSH: begin
          if (branch_taken) begin
            state     <= (FLUSH_CYCLES == 1) ? RUN : FLUSH;
            flush_cnt <= FLUSH_REMAIN;
          end else if (flush_cnt <= 3'd1) begin
            state <= RUN;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        default: begin
          state     <= FAULT;
          mem_fault <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller with FLUSH_CYCLES=2 and
// MEM_TIMEOUT=4: the driver pushes hand-computed expectations, the monitor
// pops and compares them mid-cycle.
module tb_hazard_stall_controller;

  typedef struct {
    logic       rst_n;
    logic [3:0] rn, rm;
    logic       use_rn, use_rm;
    logic [3:0] ex_rd;
    logic       ex_rw, ex_mr;
    logic [3:0] mem_rd;
    logic       mem_rw;
    logic [3:0] wb_rd;
    logic       wb_rw;
    logic       br, mreq, mrdy;
  } stim_t;

  typedef struct {
    string       name;
    logic [1:0]  fa, fb;
    logic        nop, pc, ifid, flush, hold, fault;
    logic [15:0] stall;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [3:0]  id_rn, id_rm, ex_rd, mem_rd, wb_rd;
  logic        id_use_rn, id_use_rm, ex_reg_write, ex_mem_read;
  logic        mem_reg_write, wb_reg_write, branch_taken, mem_req, mem_ready;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        cu_nop_select, pc_enable, if_id_enable, if_id_flush;
  logic        ex_mem_hold, mem_fault;
  logic [15:0] stall_count;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [15:0] model_stall = 16'd0;

  hazard_stall_controller #(
    .FLUSH_CYCLES(2),
    .MEM_TIMEOUT (4),
    .CNT_W       (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .id_rn         (id_rn),
    .id_rm         (id_rm),
    .id_use_rn     (id_use_rn),
    .id_use_rm     (id_use_rm),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .branch_taken  (branch_taken),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel),
    .cu_nop_select (cu_nop_select),
    .pc_enable     (pc_enable),
    .if_id_enable  (if_id_enable),
    .if_id_flush   (if_id_flush),
    .ex_mem_hold   (ex_mem_hold),
    .mem_fault     (mem_fault),
    .stall_count   (stall_count)
  );

  // 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idle_in();
    stim_t s;
    s.rst_n = 1'b1; s.rn = 4'd0; s.rm = 4'd0; s.use_rn = 1'b0; s.use_rm = 1'b0;
    s.ex_rd = 4'd0; s.ex_rw = 1'b0; s.ex_mr = 1'b0;
    s.mem_rd = 4'd0; s.mem_rw = 1'b0; s.wb_rd = 4'd0; s.wb_rw = 1'b0;
    s.br = 1'b0; s.mreq = 1'b0; s.mrdy = 1'b0;
    return s;
  endfunction

  function automatic exp_t run_out(input string n);
    exp_t e;
    e.name = n; e.fa = 2'b00; e.fb = 2'b00;
    e.nop = 1'b0; e.pc = 1'b1; e.ifid = 1'b1; e.flush = 1'b0;
    e.hold = 1'b0; e.fault = 1'b0; e.stall = 16'd0;
    return e;
  endfunction

  function automatic exp_t rst_out(input string n);
    exp_t e = run_out(n);
    e.nop = 1'b1; e.pc = 1'b0; e.ifid = 1'b0;
    return e;
  endfunction

  function automatic exp_t bubble_out(input string n);
    exp_t e = run_out(n);
    e.nop = 1'b1; e.pc = 1'b0; e.ifid = 1'b0;
    return e;
  endfunction

  function automatic exp_t wait_out(input string n);
    exp_t e = run_out(n);
    e.pc = 1'b0; e.ifid = 1'b0; e.hold = 1'b1;
    return e;
  endfunction

  function automatic exp_t flush_out(input string n);
    exp_t e = run_out(n);
    e.flush = 1'b1; e.nop = 1'b1;
    return e;
  endfunction

  function automatic exp_t fault_out(input string n);
    exp_t e = run_out(n);
    e.pc = 1'b0; e.ifid = 1'b0; e.hold = 1'b1; e.nop = 1'b1; e.fault = 1'b1;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    reset_n = s.rst_n; id_rn = s.rn; id_rm = s.rm;
    id_use_rn = s.use_rn; id_use_rm = s.use_rm;
    ex_rd = s.ex_rd; ex_reg_write = s.ex_rw; ex_mem_read = s.ex_mr;
    mem_rd = s.mem_rd; mem_reg_write = s.mem_rw;
    wb_rd = s.wb_rd; wb_reg_write = s.wb_rw;
    branch_taken = s.br; mem_req = s.mreq; mem_ready = s.mrdy;
  endtask

  // One cycle of stimulus; the expected stall count comes from a running model
  task automatic applyStimulus(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    drive(s);
    e.stall = model_stall;
    exp_q.push_back(e);
    if (!s.rst_n)   model_stall = 16'd0;
    else if (!e.pc) model_stall = model_stall + 16'd1;
  endtask

  task automatic cmp(input string tag, input string field,
                     input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s.%s got=%0h expected=%0h", tag, field, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp(e.name, "fwd_a_sel",     16'(fwd_a_sel),     16'(e.fa));
    cmp(e.name, "fwd_b_sel",     16'(fwd_b_sel),     16'(e.fb));
    cmp(e.name, "cu_nop_select", 16'(cu_nop_select), 16'(e.nop));
    cmp(e.name, "pc_enable",     16'(pc_enable),     16'(e.pc));
    cmp(e.name, "if_id_enable",  16'(if_id_enable),  16'(e.ifid));
    cmp(e.name, "if_id_flush",   16'(if_id_flush),   16'(e.flush));
    cmp(e.name, "ex_mem_hold",   16'(ex_mem_hold),   16'(e.hold));
    cmp(e.name, "mem_fault",     16'(mem_fault),     16'(e.fault));
    cmp(e.name, "stall_count",   stall_count,        e.stall);
  endtask

  // Monitor: every cycle the DUT presents a full control word; compare mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before end of stimulus");
    $fatal(1, "[TB] timeout");
  end

  // Directed stimulus with hand-computed expectations
  initial begin
    stim_t s;
    exp_t  e;
    s = idle_in();
    s.rst_n = 1'b0;
    drive(s);
    repeat (2) @(posedge clk);

    s = idle_in(); s.rst_n = 1'b0; applyStimulus(s, rst_out("reset"));
    s = idle_in(); applyStimulus(s, run_out("idle"));

    // forwarding priority on rn
    s = idle_in(); s.rn = 4'd3; s.use_rn = 1'b1;
    s.ex_rd = 4'd3; s.ex_rw = 1'b1; s.mem_rd = 4'd3; s.mem_rw = 1'b1; s.wb_rd = 4'd3; s.wb_rw = 1'b1;
    e = run_out("fwd_ex"); e.fa = 2'b01; applyStimulus(s, e);
    s.ex_rw = 1'b0;
    e = run_out("fwd_mem"); e.fa = 2'b10; applyStimulus(s, e);
    s.mem_rw = 1'b0;
    e = run_out("fwd_wb"); e.fa = 2'b11; applyStimulus(s, e);
    s.rn = 4'd15; s.ex_rd = 4'd15; s.ex_rw = 1'b1; s.mem_rd = 4'd15; s.mem_rw = 1'b1; s.wb_rd = 4'd15;
    applyStimulus(s, run_out("fwd_pc"));
    s = idle_in(); s.rm = 4'd7; s.use_rm = 1'b1; s.ex_rd = 4'd7; s.ex_rw = 1'b1;
    s.rn = 4'd2; s.use_rn = 1'b0; s.wb_rd = 4'd2; s.wb_rw = 1'b1;
    e = run_out("fwd_b_ex"); e.fb = 2'b01; applyStimulus(s, e);

    // load-use bubble, then forward from MEM
    s = idle_in(); s.rm = 4'd5; s.use_rm = 1'b1; s.ex_rd = 4'd5; s.ex_rw = 1'b1; s.ex_mr = 1'b1;
    applyStimulus(s, bubble_out("load_use"));
    s = idle_in(); s.rm = 4'd5; s.use_rm = 1'b1; s.mem_rd = 4'd5; s.mem_rw = 1'b1;
    e = run_out("load_fwd"); e.fb = 2'b10; applyStimulus(s, e);

    // branch with simultaneous load-use: two flush cycles, no bubble
    s = idle_in(); s.br = 1'b1; s.rm = 4'd5; s.use_rm = 1'b1; s.ex_rd = 4'd5; s.ex_rw = 1'b1; s.ex_mr = 1'b1;
    applyStimulus(s, flush_out("branch"));
    s = idle_in(); applyStimulus(s, flush_out("flush_2"));
    applyStimulus(s, run_out("after_flush"));

    // memory wait, ready low three cycles
    s = idle_in(); s.mreq = 1'b1;
    applyStimulus(s, run_out("mem_start"));
    applyStimulus(s, wait_out("mem_wait1"));
    applyStimulus(s, wait_out("mem_wait2"));
    s.mrdy = 1'b1; applyStimulus(s, wait_out("mem_ready"));
    s = idle_in(); applyStimulus(s, run_out("mem_done"));

    // branch ignored while waiting, accepted on the ready cycle
    s = idle_in(); s.mreq = 1'b1;
    applyStimulus(s, run_out("mem2_start"));
    s.br = 1'b1; applyStimulus(s, wait_out("mem2_br_ignored"));
    s.mrdy = 1'b1; applyStimulus(s, wait_out("mem2_ready_br"));
    s = idle_in(); applyStimulus(s, flush_out("mem2_flush1"));
    applyStimulus(s, flush_out("mem2_flush2"));
    applyStimulus(s, run_out("mem2_run"));

    // zero-wait access
    s = idle_in(); s.mreq = 1'b1; s.mrdy = 1'b1;
    applyStimulus(s, run_out("zero_wait"));
    s = idle_in(); applyStimulus(s, run_out("zero_wait_after"));

    // reset in the middle of a flush
    s = idle_in(); s.br = 1'b1; applyStimulus(s, flush_out("br_before_rst"));
    s = idle_in(); s.rst_n = 1'b0; applyStimulus(s, rst_out("rst_mid_flush1"));
    applyStimulus(s, rst_out("rst_mid_flush2"));
    s = idle_in(); applyStimulus(s, run_out("run_after_rst"));

    // timeout into FAULT
    s = idle_in(); s.mreq = 1'b1;
    applyStimulus(s, run_out("to_start"));
    for (int i = 1; i <= 4; i++) applyStimulus(s, wait_out($sformatf("to_wait%0d", i)));
    applyStimulus(s, fault_out("fault1"));
    s = idle_in(); s.mrdy = 1'b1; applyStimulus(s, fault_out("fault_sticky"));
    s = idle_in(); s.br = 1'b1; applyStimulus(s, fault_out("fault_branch"));
    s = idle_in(); s.rst_n = 1'b0;
    e = rst_out("fault_rst1"); e.fault = 1'b1; applyStimulus(s, e);
    applyStimulus(s, rst_out("fault_rst2"));
    s = idle_in(); applyStimulus(s, run_out("fault_cleared"));

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
